// File: rtl/panda_pkg.sv
// Shared types for the panda core slice: FSM state encoding of the boot-time
// instruction-memory loader.
package panda_pkg;

    typedef enum logic [2:0] {
        LOADER_IDLE,
        LOADER_LEN0,
        LOADER_LEN1,
        LOADER_DATA,
        LOADER_CSUM,
        LOADER_DONE,
        LOADER_ERROR
    } loader_state_e;

endpackage

// File: rtl/panda_imem_loader.sv
// Boot loader: byte stream (16-bit LE count, then LE words) into instruction RAM from word 0, core held in reset until done.
// Write lands 1 cycle after the 4th byte handshake; ready depends on state only. Optional LOADER_CHECKSUM_EN adds an XOR check byte.
module panda_imem_loader
    import panda_pkg::*;
#(
    parameter int unsigned InstrMemDepth = 32,
    localparam int unsigned AddrWidth    = $clog2(InstrMemDepth)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 byte_valid_i,
    output logic                 byte_ready_o,
    input  logic [7:0]           byte_data_i,
    output logic                 mem_ce_o,
    output logic [3:0]           mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_data_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 error_o,
    output logic                 core_rst_no
);

    loader_state_e          r_state;
    loader_state_e          w_state_d;
    loader_state_e          w_fin_state;
    logic [7:0]             r_len_lo;
    logic [15:0]            r_len;
    logic [AddrWidth-1:0]   r_widx;
    logic [1:0]             r_bcnt;
    logic [23:0]            r_asm;
    logic [3:0]             r_we;
    logic [AddrWidth-1:0]   r_addr;
    logic [31:0]            r_data;
    logic                   r_core_rst_n;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]             r_xor;
`endif

    logic        w_hs;
    logic        w_start_ok;
    logic        w_last_word;
    logic [15:0] w_len;

    assign byte_ready_o = (r_state == LOADER_LEN0) || (r_state == LOADER_LEN1) ||
                          (r_state == LOADER_DATA) || (r_state == LOADER_CSUM);
    assign w_hs         = byte_valid_i && byte_ready_o;
    assign w_start_ok   = start_i && ((r_state == LOADER_IDLE) || (r_state == LOADER_DONE) ||
                                      (r_state == LOADER_ERROR));
    assign w_len        = {byte_data_i, r_len_lo};
    assign w_last_word  = (16'(r_widx) == (r_len - 16'd1));

`ifdef LOADER_CHECKSUM_EN
    assign w_fin_state  = LOADER_CSUM;
`else
    assign w_fin_state  = LOADER_DONE;
`endif

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            LOADER_IDLE, LOADER_DONE, LOADER_ERROR: begin
                if (start_i) w_state_d = LOADER_LEN0;
            end
            LOADER_LEN0: begin
                if (w_hs) w_state_d = LOADER_LEN1;
            end
            LOADER_LEN1: begin
                if (w_hs) begin
                    if ({1'b0, w_len} > 17'(InstrMemDepth)) w_state_d = LOADER_ERROR;
                    else if (w_len == 16'd0)                 w_state_d = w_fin_state;
                    else                                     w_state_d = LOADER_DATA;
                end
            end
            LOADER_DATA: begin
                if (w_hs && (r_bcnt == 2'd3) && w_last_word) w_state_d = w_fin_state;
            end
`ifdef LOADER_CHECKSUM_EN
            LOADER_CSUM: begin
                if (w_hs) w_state_d = (byte_data_i == r_xor) ? LOADER_DONE : LOADER_ERROR;
            end
`endif
            default: w_state_d = LOADER_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= LOADER_IDLE;
            r_len_lo     <= '0;
            r_len        <= '0;
            r_widx       <= '0;
            r_bcnt       <= '0;
            r_asm        <= '0;
            r_we         <= '0;
            r_addr       <= '0;
            r_data       <= '0;
            r_core_rst_n <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor        <= '0;
`endif
        end else begin
            r_state      <= w_state_d;
            r_we         <= 4'h0;
            // Rises the cycle after DONE is entered, so never alongside the last write.
            r_core_rst_n <= (r_state == LOADER_DONE) && (w_state_d == LOADER_DONE);
            if (w_start_ok) begin
                r_widx <= '0;
                r_bcnt <= '0;
`ifdef LOADER_CHECKSUM_EN
                r_xor  <= '0;
`endif
            end
            if (w_hs && (r_state == LOADER_LEN0)) r_len_lo <= byte_data_i;
            if (w_hs && (r_state == LOADER_LEN1)) r_len    <= w_len;
            if (w_hs && (r_state == LOADER_DATA)) begin
                r_asm  <= {byte_data_i, r_asm[23:8]};
                r_bcnt <= r_bcnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                r_xor  <= r_xor ^ byte_data_i;
`endif
                if (r_bcnt == 2'd3) begin
                    r_we   <= 4'hF;
                    r_data <= {byte_data_i, r_asm};
                    r_addr <= r_widx;
                    r_widx <= r_widx + 1'b1;
                end
            end
        end
    end

    assign mem_we_o    = r_we;
    assign mem_ce_o    = |r_we;
    assign mem_addr_o  = r_addr;
    assign mem_data_o  = r_data;
    assign busy_o      = byte_ready_o;
    assign done_o      = (r_state == LOADER_DONE);
    assign error_o     = (r_state == LOADER_ERROR);
    assign core_rst_no = r_core_rst_n;

endmodule

// File: doc/panda_imem_loader.md
Name: panda_imem_loader

Overview:
Boot-time writer for the instruction memory; the core's fetch path is the reader of the same RAM port. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. It writes those words sequentially into the instruction RAM from address 0 and holds the core in reset until the image is complete. It sits between the host byte link (UART RX or debug bridge) and the instruction RAM write port.

Parameters:
InstrMemDepth, 32, instruction RAM depth in 32-bit words; power of two, minimum 2.
AddrWidth, $clog2(InstrMemDepth), derived word-address width; localparam, not overridable.

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
start_i  input  1  single-cycle pulse that begins a new load; ignored while busy_o=1
byte_valid_i  input  1  byte_data_i is valid
byte_ready_o  output  1  loader accepts a byte this cycle
byte_data_i  input  8  stream byte
mem_ce_o  output  1  RAM chip enable, equal to any bit of mem_we_o
mem_we_o  output  4  RAM byte write enables; 4'hF for a word write, else 4'h0
mem_addr_o  output  AddrWidth  RAM word address
mem_data_o  output  32  RAM write data
busy_o  output  1  load in progress
done_o  output  1  last load completed successfully (level)
error_o  output  1  last load aborted (level)
core_rst_no  output  1  active-low core reset; 0 until a load completes successfully

Behaviour:
- Reset clock is clk_i; rst_ni is asynchronous, active-low.
- Reset values: state IDLE; byte_ready_o=0, mem_we_o=0, mem_ce_o=0, mem_addr_o=0, mem_data_o=0, busy_o=0, done_o=0, error_o=0, core_rst_no=0.
- Handshake: a byte is consumed only when byte_valid_i=1 and byte_ready_o=1 in the same cycle.
- byte_ready_o is 1 exactly in states LEN0, LEN1, DATA and CSUM. It depends only on state, not on byte_valid_i.
- Stream format: count N as 16-bit little-endian (LEN0 takes the low byte, LEN1 the high byte), then 4*N data bytes, little-endian per word. The first byte of each word goes to bits [7:0].
- FSM states:
  - IDLE: start_i -> LEN0. Clear done_o and error_o, set busy_o, drive core_rst_no=0, clear the word index.
  - LEN0: byte accepted -> LEN1.
  - LEN1: byte accepted -> evaluate N.
    - N > InstrMemDepth -> ERROR.
    - N = 0 -> CSUM if LOADER_CHECKSUM_EN is defined, else DONE.
    - Otherwise -> DATA.
  - DATA: each accepted byte shifts into a 32-bit assembly register and a 2-bit byte counter increments.
    - On the 4th byte, mem_we_o=4'hF, mem_data_o=assembled word and mem_addr_o=word index are registered, so the write is visible exactly 1 cycle after the handshake.
    - The word index then increments.
    - After word N-1 is accepted -> CSUM or DONE, as for N=0.
  - DONE: busy_o=0, done_o=1, core_rst_no=1. start_i -> LEN0 and drops core_rst_no in the next cycle.
  - ERROR: busy_o=0, error_o=1, core_rst_no=0. start_i -> LEN0.
- mem_we_o is a single-cycle pulse. Back-to-back words with byte_valid_i held high give one write every 4 cycles.
- The last write's pulse occurs in the same cycle the FSM enters DONE. core_rst_no therefore rises no earlier than the cycle after the final write.
- No address wrap: N ≤ InstrMemDepth guarantees word index ≤ InstrMemDepth-1.
- Gaps in byte_valid_i stall the FSM indefinitely; there is no timeout.
- start_i while busy_o=1 is ignored.
- Asynchronous reset mid-load returns to IDLE at once. Partially written RAM contents are not cleared.

Optional Feature:
LOADER_CHECKSUM_EN:
- Defined: after the data bytes, the FSM enters CSUM and accepts one byte.
  - It compares that byte with the XOR of all data bytes, excluding the count bytes; XOR is 8'h00 when N=0.
  - Match -> DONE. Mismatch -> ERROR, and core_rst_no stays 0.
  - Words already written remain in RAM.
- Undefined: the CSUM state and the XOR register do not exist. The last data byte (or LEN1 when N=0) goes directly to DONE.

Decomposition:
- panda_pkg gains typedef enum logic [2:0] loader_state_e {LOADER_IDLE, LOADER_LEN0, LOADER_LEN1, LOADER_DATA, LOADER_CSUM, LOADER_DONE, LOADER_ERROR}.
- No sub-module: the byte-to-word assembly is a shift register plus counter inside the block.
- The top level muxes the RAM port: loader drives it while core_rst_no=0, fetch otherwise.

Test Plan:
- Reset then idle: core_rst_no=0, done_o=0, byte_ready_o=0, no writes for 20 cycles.
- start_i, then bytes 02 00 | 13 00 00 00 | 93 00 10 00 with continuous valid -> writes addr0=32'h00000013 and addr1=32'h00100093, 4 cycles apart. done_o=1 and core_rst_no=1 follow the last write.
- Count bytes 21 00 with InstrMemDepth=32 (N=33) -> ERROR: error_o=1, core_rst_no=0, no writes, byte_ready_o=0. A later start_i followed by a valid image completes with done_o=1.
- Random byte_valid_i gaps on a 3-word image with start_i pulsed mid-load -> identical RAM contents; start_i ignored; exactly 3 write pulses.
- rst_ni asserted after 6 data bytes -> immediate IDLE with all outputs at reset values. A fresh start_i plus a 1-word image writes addr0 only.
- With LOADER_CHECKSUM_EN, N=1, data AA BB CC DD:
  - checksum 00 -> done_o=1
  - checksum 01 -> error_o=1, core_rst_no=0, addr0 still holds 32'hDDCCBBAA.
